// File: rtl/tmux_arb.sv
// Packet-aware N:1 arbiter/mux with a one-entry registered output stage.
// A granted channel keeps the output until its last beat has been accepted.
module tmux_arb #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned RR       = 1,
    localparam int unsigned CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS-1:0]       in_last,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    output logic                      out_last,
    output logic [CW-1:0]             out_chan,
    input  logic                      out_ready
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t            state;
    logic [CW-1:0]     grant;
    logic [CW-1:0]     ptr;

    logic              free_c;
    logic              any_c;
    logic [CW-1:0]     pick_c;
    logic [CW-1:0]     chan_c;
    logic [WIDTH-1:0]  data_c;
    logic              last_c;
    logic              load_c;
    logic [CW-1:0]     ptr_nxt_c;

    assign free_c = !out_valid || out_ready;

    // Pick the first valid channel, scanning upward from the pointer (or from 0 in fixed mode).
    always_comb begin : arb
        int unsigned base;
        int unsigned k;
        any_c  = 1'b0;
        pick_c = '0;
        base   = (RR != 0) ? 32'(ptr) : 32'd0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            k = base + i;
            if (k >= CHANNELS) begin
                k = k - CHANNELS;
            end
            for (int unsigned j = 0; j < CHANNELS; j++) begin
                if (!any_c && (j == k) && in_valid[j]) begin
                    any_c  = 1'b1;
                    pick_c = CW'(j);
                end
            end
        end
    end

    assign chan_c = (state == LOCKED) ? grant : pick_c;

    // Source-channel mux plus the handshake; in_ready never looks at in_data.
    always_comb begin : mux
        data_c   = '0;
        last_c   = 1'b0;
        in_ready = '0;
        for (int unsigned j = 0; j < CHANNELS; j++) begin
            if (CW'(j) == chan_c) begin
                data_c = in_data[j*WIDTH +: WIDTH];
                last_c = in_last[j];
                if (!reset && free_c) begin
                    in_ready[j] = (state == LOCKED) || any_c;
                end
            end
        end
    end

    assign load_c = |(in_ready & in_valid);

    always_comb begin : ptr_next
        int unsigned n;
        n = 32'(chan_c) + 32'd1;
        if (n >= CHANNELS) begin
            n = 32'd0;
        end
        ptr_nxt_c = CW'(n);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            grant     <= '0;
            ptr       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_chan  <= '0;
        end else begin
            if (load_c) begin
                out_valid <= 1'b1;
                out_data  <= data_c;
                out_last  <= last_c;
                out_chan  <= chan_c;
                if (last_c) begin
                    ptr <= ptr_nxt_c;
                end
                case (state)
                    IDLE: begin
                        grant <= chan_c;
                        if (!last_c) begin
                            state <= LOCKED;
                        end
                    end
                    LOCKED: begin
                        if (last_c) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tmux_arb.sv
// Directed bench for tmux_arb: a round-robin and a fixed-priority instance share one stimulus.
module tb_tmux_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_last;
    logic        out_ready;

    logic [3:0]  rr_ready, fp_ready;
    logic [7:0]  rr_data, fp_data;
    logic        rr_valid, fp_valid;
    logic        rr_last, fp_last;
    logic [1:0]  rr_chan, fp_chan;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_d [4];

    always #5 clk = ~clk;

    tmux_arb #(.WIDTH(8), .CHANNELS(4), .RR(1)) dut_rr (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(rr_ready), .out_data(rr_data),
        .out_valid(rr_valid), .out_last(rr_last), .out_chan(rr_chan),
        .out_ready(out_ready)
    );

    tmux_arb #(.WIDTH(8), .CHANNELS(4), .RR(0)) dut_fp (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(fp_ready), .out_data(fp_data),
        .out_valid(fp_valid), .out_last(fp_last), .out_chan(fp_chan),
        .out_ready(out_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input logic [7:0] d0, input logic [7:0] d1,
                            input logic [7:0] d2, input logic [7:0] d3);
        in_data = {d3, d2, d1, d0};
    endtask

    initial begin
        exp_d[0] = 8'h10; exp_d[1] = 8'h21; exp_d[2] = 8'h32; exp_d[3] = 8'h43;
        reset = 1'b1; in_valid = '0; in_last = '0; in_data = '0; out_ready = 1'b1;
        tick();
        tick();

        // Reset state, and no in_ready while reset is high
        in_valid = 4'hF;
        #1;
        check("rst_rr_ready", 32'(rr_ready), 32'h0);
        check("rst_fp_ready", 32'(fp_ready), 32'h0);
        check("rst_valid", 32'(rr_valid), 32'h0);
        check("rst_data", 32'(rr_data), 32'h0);
        check("rst_chan", 32'(rr_chan), 32'h0);
        check("rst_last", 32'(rr_last), 32'h0);

        // All four channels single-beat: round-robin rotates, fixed stays on ch0
        set_data(8'h10, 8'h21, 8'h32, 8'h43);
        in_last = 4'hF;
        reset = 1'b0;
        #1;
        check("rr_ready0", 32'(rr_ready), 32'h1);
        check("fp_ready0", 32'(fp_ready), 32'h1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rr_chan", 32'(rr_chan), 32'(i % 4));
            check("rr_data", 32'(rr_data), 32'(exp_d[i % 4]));
            check("rr_valid", 32'(rr_valid), 32'h1);
            check("rr_ready", 32'(rr_ready), 32'(1 << ((i + 1) % 4)));
            check("fp_chan", 32'(fp_chan), 32'h0);
            check("fp_data", 32'(fp_data), 32'h10);
            check("fp_ready", 32'(fp_ready), 32'h1);
        end

        // ch2 3-beat packet holds the grant against ch1; pointer lands on 3
        reset = 1'b1; in_valid = '0;
        tick();
        reset = 1'b0;
        in_valid = 4'b0100; in_last = 4'b0000;
        set_data(8'h00, 8'h11, 8'hAA, 8'h00);
        #1;
        check("pk_ready_a", 32'(rr_ready), 32'h4);
        tick();
        check("pk_chan_a", 32'(rr_chan), 32'h2);
        check("pk_data_a", 32'(rr_data), 32'hAA);
        check("pk_last_a", 32'(rr_last), 32'h0);
        in_valid = 4'b0110; in_last = 4'b0010;
        set_data(8'h00, 8'h11, 8'hBB, 8'h00);
        #1;
        check("pk_ready_b", 32'(rr_ready), 32'h4);
        tick();
        check("pk_data_b", 32'(rr_data), 32'hBB);
        check("pk_chan_b", 32'(rr_chan), 32'h2);
        set_data(8'h00, 8'h11, 8'hCC, 8'h00);
        in_last = 4'b0110;
        #1;
        check("pk_ready_c", 32'(rr_ready), 32'h4);
        tick();
        check("pk_data_c", 32'(rr_data), 32'hCC);
        check("pk_last_c", 32'(rr_last), 32'h1);
        check("pk_chan_c", 32'(rr_chan), 32'h2);
        in_valid = 4'b1010;
        #1;
        check("pk_ptr3", 32'(rr_ready), 32'h8);
        in_valid = 4'b0010;
        #1;
        check("pk_ready_ch1", 32'(rr_ready), 32'h2);
        tick();
        check("pk_chan_ch1", 32'(rr_chan), 32'h1);
        check("pk_data_ch1", 32'(rr_data), 32'h11);

        // Backpressure: 0x5A held stable for 5 cycles, then replaced without a bubble
        in_valid = 4'b0001; in_last = 4'hF;
        set_data(8'h5A, 8'h00, 8'h00, 8'h00);
        #1;
        check("bp_ready_ld", 32'(rr_ready), 32'h1);
        tick();
        check("bp_data_ld", 32'(rr_data), 32'h5A);
        out_ready = 1'b0;
        in_valid = 4'hF;
        set_data(8'h66, 8'h77, 8'h88, 8'h99);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_ready", 32'(rr_ready), 32'h0);
            tick();
            check("bp_data", 32'(rr_data), 32'h5A);
            check("bp_chan", 32'(rr_chan), 32'h0);
            check("bp_valid", 32'(rr_valid), 32'h1);
            check("bp_last", 32'(rr_last), 32'h1);
        end
        out_ready = 1'b1;
        #1;
        check("bp_ready_rel", 32'(rr_ready), 32'h2);
        tick();
        check("bp_data_next", 32'(rr_data), 32'h77);
        check("bp_chan_next", 32'(rr_chan), 32'h1);

        // Reset in the middle of a ch1 packet
        in_valid = 4'b0010; in_last = 4'b0000;
        set_data(8'h00, 8'hB1, 8'h00, 8'h00);
        #1;
        check("mr_ready_a", 32'(rr_ready), 32'h2);
        tick();
        check("mr_data_a", 32'(rr_data), 32'hB1);
        check("mr_chan_a", 32'(rr_chan), 32'h1);
        set_data(8'h00, 8'hB2, 8'h00, 8'h00);
        tick();
        check("mr_data_b", 32'(rr_data), 32'hB2);
        reset = 1'b1;
        #1;
        check("mr_ready_rst", 32'(rr_ready), 32'h0);
        tick();
        reset = 1'b0;
        check("mr_valid", 32'(rr_valid), 32'h0);
        in_valid = 4'b1010; in_last = 4'b1000;
        set_data(8'h00, 8'hB3, 8'h00, 8'hD3);
        #1;
        check("mr_ptr0", 32'(rr_ready), 32'h2);
        in_valid = 4'b1000;
        #1;
        check("mr_ready_ch3", 32'(rr_ready), 32'h8);
        tick();
        check("mr_chan_ch3", 32'(rr_chan), 32'h3);
        check("mr_data_ch3", 32'(rr_data), 32'hD3);

        // Locked ch0 goes idle mid-packet; ch1 must wait
        in_valid = 4'b0001; in_last = 4'b0000;
        set_data(8'hC0, 8'hE1, 8'h00, 8'h00);
        #1;
        check("lk_ready_a", 32'(rr_ready), 32'h1);
        tick();
        check("lk_data_a", 32'(rr_data), 32'hC0);
        check("lk_chan_a", 32'(rr_chan), 32'h0);
        in_valid = 4'b0010; in_last = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("lk_ready_hold", 32'(rr_ready), 32'h1);
            tick();
            check("lk_valid_hold", 32'(rr_valid), 32'h0);
        end
        in_valid = 4'b0011; in_last = 4'b0011;
        set_data(8'hC1, 8'hE1, 8'h00, 8'h00);
        #1;
        check("lk_ready_b", 32'(rr_ready), 32'h1);
        tick();
        check("lk_data_b", 32'(rr_data), 32'hC1);
        check("lk_last_b", 32'(rr_last), 32'h1);
        check("lk_chan_b", 32'(rr_chan), 32'h0);
        #1;
        check("lk_ready_ch1", 32'(rr_ready), 32'h2);
        tick();
        check("lk_data_ch1", 32'(rr_data), 32'hE1);
        check("lk_chan_ch1", 32'(rr_chan), 32'h1);
        in_valid = '0;
        tick();
        check("lk_drain", 32'(rr_valid), 32'h0);

        // Fixed priority picks the lowest valid index
        reset = 1'b1;
        tick();
        reset = 1'b0;
        in_valid = 4'b1100;
        #1;
        check("fp_pick2", 32'(fp_ready), 32'h4);
        in_valid = 4'b1110;
        #1;
        check("fp_pick1", 32'(fp_ready), 32'h2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
